uart_tx_arbiter: RTL and testbench

Shares a single byte-serial UART transmitter among NUM_REQ requesters using round-robin arbitration with packet locking. Each requester presents bytes over a valid/ready handshake and marks the final byte of a packet with req_last. The arbiter issues one tx_start pulse per byte to the transmitter and waits for tx_done before accepting the next byte. A watchdog releases a stalled grant.

---
 rtl/uart_tx_arbiter_pkg.sv | 19 +
 rtl/uart_tx_arbiter_rr_pick.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encodings, width helper.
package uart_tx_arbiter_pkg;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_SEND      = 2'd1;
   localparam logic [1:0] ST_WAIT_DONE = 2'd2;

   localparam int DEFAULT_DATA_W = 8;

   // Bits needed to index n items; never less than one bit.
   function automatic int clog2(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 32; i++)
         if ((1 << w) < n) w = w + 1;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module uart_tx_arbiter_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic               found,
   output logic [IDW-1:0]     idx
);

   localparam logic [IDW:0] N_V = NUM_REQ[IDW:0];

   logic [NUM_REQ-1:0] rot;
   logic [IDW-1:0]     hit;
   logic [IDW:0]       sum;

   // Rotate so ptr lands on bit 0, priority-encode, then rotate the index back.
   always_comb begin
      rot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         int k;
         k = i + int'(ptr);
         if (k >= NUM_REQ) k = k - NUM_REQ;
         rot[i] = req[k];
      end
      found = |rot;
      hit   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (rot[i]) hit = IDW'(i);
      sum = {1'b0, hit} + {1'b0, ptr};
      if (sum >= N_V) sum = sum - N_V;
      idx = sum[IDW-1:0];
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter feeding one byte-serial UART transmitter.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_W         = DEFAULT_DATA_W,
   parameter int TIMEOUT_CYCLES = 65535,
   localparam int IDW           = clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ-1:0]          req_last,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        tx_start,
   output logic [DATA_W-1:0]           tx_data,
   input  logic                        tx_busy,
   input  logic                        tx_done,
   output logic [IDW-1:0]              grant_id,
   output logic                        grant_active,
   output logic                        timeout_err
);

   localparam int              CNT_W    = clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDW-1:0]   ID_LAST  = IDW'(NUM_REQ - 1);

   logic [1:0]        state;
   logic [IDW-1:0]    ptr;
   logic [CNT_W-1:0]  wait_cnt;
   logic              last_q;

   logic              pick_found;
   logic [IDW-1:0]    pick_idx;
   logic              own_valid, own_last, xfer, wait_hit;
   logic [DATA_W-1:0] own_data;
   logic [IDW-1:0]    ptr_next;

   uart_tx_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
      .req   (req_valid),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Owner's request view and the handshake; only the owner ever sees ready.
   always_comb begin
      own_valid = req_valid[grant_id];
      own_last  = req_last[grant_id];
      own_data  = req_data[grant_id*DATA_W +: DATA_W];
      xfer      = (state == ST_SEND) && !tx_busy && own_valid;
      wait_hit  = (wait_cnt == CNT_LAST);
      ptr_next  = (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;
      req_ready = '0;
      if (state == ST_SEND && !tx_busy) req_ready[grant_id] = 1'b1;
   end

   // Arbitration FSM, byte launch and watchdog; tx_done beats the watchdog.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         ptr          <= '0;
         wait_cnt     <= '0;
         last_q       <= 1'b0;
         tx_start     <= 1'b0;
         tx_data      <= '0;
         grant_id     <= '0;
         grant_active <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         tx_start    <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  grant_id     <= pick_idx;
                  grant_active <= 1'b1;
                  state        <= ST_SEND;
                  wait_cnt     <= '0;
               end
            end
            ST_SEND: begin
               if (xfer) begin
                  tx_data  <= own_data;
                  last_q   <= own_last;
                  tx_start <= 1'b1;
                  state    <= ST_WAIT_DONE;
                  wait_cnt <= '0;
               end else if (!own_valid) begin
                  if (wait_hit) begin
                     timeout_err  <= 1'b1;
                     grant_active <= 1'b0;
                     ptr          <= ptr_next;
                     state        <= ST_IDLE;
                     wait_cnt     <= '0;
                  end else begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end
            end
            ST_WAIT_DONE: begin
               if (tx_done) begin
                  wait_cnt <= '0;
                  if (last_q) begin
                     grant_active <= 1'b0;
                     ptr          <= ptr_next;
                     state        <= ST_IDLE;
                  end else begin
                     state <= ST_SEND;
                  end
               end else if (wait_hit) begin
                  timeout_err  <= 1'b1;
                  grant_active <= 1'b0;
                  ptr          <= ptr_next;
                  state        <= ST_IDLE;
                  wait_cnt     <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: sends queue expected (owner, byte) pairs, monitor checks each tx_start.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]  req_last;
   logic [N-1:0]  req_ready;
   logic          tx_start;
   logic [DW-1:0] tx_data;
   logic          tx_busy;
   logic          tx_done = 1'b0;
   logic [1:0]    grant_id;
   logic          grant_active;
   logic          timeout_err;

   logic model_busy = 1'b0;
   logic force_busy = 1'b0;
   logic tx_auto    = 1'b1;
   assign tx_busy = model_busy | force_busy;

   int checks   = 0;
   int failures = 0;

   logic [8:0] rq [N][$];
   logic [9:0] exp_q [$];

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
      .grant_id(grant_id), .grant_active(grant_active), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic send(input int id, input logic [7:0] d, input logic last);
      rq[id].push_back({last, d});
      exp_q.push_back({id[1:0], d});
   endtask

   task automatic wait_idle(input string name);
      int n;
      bit done;
      n = 0;
      done = 0;
      while (!done && n < 400) begin
         @(posedge clk); #1;
         n++;
         done = (exp_q.size() == 0) && !grant_active && !model_busy &&
                rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && rq[3].size() == 0;
      end
      chk({name, "_drain"}, 32'(done), 32'd1);
   endtask

   task automatic wait_sig(input string name, input int which, input int budget);
      int n;
      bit hit;
      n = 0;
      hit = 0;
      while (!hit && n < budget) begin
         @(posedge clk); #1;
         n++;
         hit = (which == 0) ? grant_active : (which == 1) ? tx_start : timeout_err;
      end
      chk({name, "_seen"}, 32'(hit), 32'd1);
   endtask

   // Requester models: hold each byte until it is seen accepted.
   initial begin
      logic [N-1:0] acc;
      logic [8:0]   tmp;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(negedge clk);
         acc = req_valid & req_ready;
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            if (acc[i]) tmp = rq[i].pop_front();
            if (rq[i].size() > 0) begin
               req_valid[i]          = 1'b1;
               req_data[i*DW +: DW]  = rq[i][0][7:0];
               req_last[i]           = rq[i][0][8];
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
   end

   // Transmitter model: busy for three cycles after tx_start, then one tx_done pulse.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (tx_start && tx_auto) begin
            model_busy = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            model_busy = 1'b0;
            tx_done    = 1'b1;
            @(posedge clk); #1;
            tx_done = 1'b0;
         end
      end
   end

   // Monitor: every tx_start must match the oldest expected (owner, byte).
   initial begin
      logic [9:0] e;
      forever begin
         @(negedge clk);
         if (tx_start) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_tx_start", {22'd0, grant_id, tx_data}, 32'h3ff);
            end else begin
               e = exp_q.pop_front();
               chk("tx_byte", {22'd0, grant_id, tx_data}, {22'd0, e});
            end
         end
      end
   end

   initial begin
      int n;
      #1;
      chk("rst_outputs", {24'd0, req_ready, tx_start, grant_active, timeout_err, grant_id[0]}, 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Single byte from requester 0
      send(0, 8'h55, 1'b1);
      wait_sig("single_grant", 0, 20);
      chk("single_grant_id", 32'(grant_id), 32'd0);
      chk("single_ready", 32'(req_ready), 32'b0001);
      @(posedge clk); #1;
      chk("single_start", 32'(tx_start), 32'd1);
      chk("single_data", 32'(tx_data), 32'h55);
      wait_idle("single");

      // Pointer advanced to 1: requester 1 beats requester 0
      send(1, 8'h61, 1'b1);
      send(0, 8'h60, 1'b1);
      wait_idle("ptr_after_single");

      // Fresh pointer: full rotation, then wrap from 3 to 0
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      send(0, 8'hA0, 1'b1);
      send(1, 8'hA1, 1'b1);
      send(2, 8'hA2, 1'b1);
      send(3, 8'hA3, 1'b1);
      wait_idle("round_robin");
      send(0, 8'hB0, 1'b1);
      send(3, 8'hB3, 1'b1);
      wait_idle("rr_wrap");

      // Packet lock: requester 2 waits out requester 1's three-byte packet
      send(1, 8'h11, 1'b0);
      send(1, 8'h22, 1'b0);
      send(1, 8'h33, 1'b1);
      send(2, 8'h44, 1'b1);
      wait_idle("packet_lock");

      // Back-pressure: transmitter busy on grant, nothing may be accepted or started
      force_busy = 1'b1;
      send(3, 8'h77, 1'b1);
      wait_sig("busy_grant", 0, 20);
      for (int i = 0; i < 10; i++) begin
         chk("busy_hold", {30'd0, |req_ready, tx_start}, 32'd0);
         @(posedge clk); #1;
      end
      force_busy = 1'b0;
      wait_idle("busy_release");

      // Watchdog in WAIT_DONE: no tx_done ever returned
      tx_auto = 1'b0;
      send(0, 8'h66, 1'b1);
      send(1, 8'h67, 1'b1);
      wait_sig("wd_start", 1, 20);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!timeout_err && n < 40);
      chk("wd_cycles", 32'(n), 32'd8);
      chk("wd_released", 32'(grant_active), 32'd0);
      @(posedge clk); #1;
      chk("wd_one_shot", 32'(timeout_err), 32'd0);
      tx_auto = 1'b1;
      wait_idle("wd_next_owner");

      // Watchdog on an in-packet gap: requester 3 takes over afterwards
      send(2, 8'h81, 1'b0);
      send(3, 8'h91, 1'b1);
      wait_sig("gap_timeout", 2, 80);
      wait_idle("gap_next_owner");

      // Reset while waiting for tx_done
      tx_auto = 1'b0;
      send(1, 8'hC1, 1'b1);
      wait_sig("rstmid_start", 1, 20);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_outputs", {25'd0, req_ready, tx_start, grant_active, timeout_err}, 32'd0);
      chk("rstmid_data_id", {22'd0, grant_id, tx_data}, 32'd0);
      @(negedge clk) rst = 1'b0;
      tx_auto = 1'b1;
      send(0, 8'hD0, 1'b1);
      send(2, 8'hD2, 1'b1);
      wait_idle("rstmid_resume");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
